// File: rtl/mtsp_launch_pkg.sv
// Shared types for the MTSP launch controller.
package mtsp_launch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    RUN      = 2'd3
  } state_t;

  // Width of the acknowledge-timeout counter for a given limit.
  function automatic int ack_cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mtsp_launch_ack.sv
// Acknowledge tracker: sticky per-core ack record plus the WAIT_ACK timeout counter.
module mtsp_launch_ack
  import mtsp_launch_pkg::*;
#(
  parameter int CORE_SIZE = 4,
  parameter int ACK_LIMIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [CORE_SIZE-1:0] mask,
  input  logic [CORE_SIZE-1:0] busy,
  output logic                 all_acked,
  output logic                 timeout
);

  localparam int CW = ack_cnt_width(ACK_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(ACK_LIMIT);

  logic [CORE_SIZE-1:0] ack_seen;
  logic [CORE_SIZE-1:0] ack_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_inc;

  // Updated ack record includes this cycle's busy so a one-cycle pulse counts immediately.
  always_comb begin
    ack_next  = ack_seen | (busy & mask);
    all_acked = (ack_next == mask);
    cnt_inc   = cnt + 1'b1;
    timeout   = enable && !all_acked && (cnt_inc == LIMIT);
  end

  // Ack record and timeout counter; cleared on reset or when a new launch is accepted.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ack_seen <= '0;
      cnt      <= '0;
    end else if (enable) begin
      ack_seen <= ack_next;
      if (!all_acked) begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/mtsp_launch.sv
// Launch controller: fans a host START out as per-core start pulses, waits for every
// selected core to acknowledge via busy, then reports DONE (or ERROR on ack timeout).
module mtsp_launch
  import mtsp_launch_pkg::*;
#(
  parameter int CORE_SIZE = 4,
  parameter int ACK_LIMIT = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CORE_SIZE-1:0] CORE_MASK,
  output logic                 READY,
  output logic                 BUSY,
  output logic [CORE_SIZE-1:0] ACTIVE_MASK,
  output logic [CORE_SIZE-1:0] CORE_START,
  input  logic [CORE_SIZE-1:0] CORE_BUSY,
  output logic                 DONE,
  output logic                 ERROR
);

  state_t               state;
  state_t               state_next;
  logic [CORE_SIZE-1:0] mask_next;
  logic [CORE_SIZE-1:0] cstart_next;
  logic                 done_next;
  logic                 error_next;
  logic                 ack_clear;
  logic                 ack_enable;
  logic                 all_acked;
  logic                 timeout;

  mtsp_launch_ack #(
    .CORE_SIZE (CORE_SIZE),
    .ACK_LIMIT (ACK_LIMIT)
  ) u_ack (
    .clk       (CLK),
    .rst       (RST),
    .clear     (ack_clear),
    .enable    (ack_enable),
    .mask      (ACTIVE_MASK),
    .busy      (CORE_BUSY),
    .all_acked (all_acked),
    .timeout   (timeout)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_next  = state;
    mask_next   = ACTIVE_MASK;
    cstart_next = '0;
    done_next   = 1'b0;
    error_next  = 1'b0;
    ack_clear   = 1'b0;
    ack_enable  = 1'b0;
    unique case (state)
      IDLE: begin
        if (START && (CORE_MASK != '0)) begin
          state_next  = LAUNCH;
          mask_next   = CORE_MASK;
          cstart_next = CORE_MASK;
          ack_clear   = 1'b1;
        end
      end
      LAUNCH: begin
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        ack_enable = 1'b1;
        if (all_acked) begin
          state_next = RUN;
        end else if (timeout) begin
          state_next = IDLE;
          mask_next  = '0;
          error_next = 1'b1;
        end
      end
      RUN: begin
        if ((CORE_BUSY & ACTIVE_MASK) == '0) begin
          state_next = IDLE;
          mask_next  = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered outputs; READY/BUSY are registered from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      ACTIVE_MASK <= '0;
      CORE_START  <= '0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
      READY       <= 1'b1;
      BUSY        <= 1'b0;
    end else begin
      state       <= state_next;
      ACTIVE_MASK <= mask_next;
      CORE_START  <= cstart_next;
      DONE        <= done_next;
      ERROR       <= error_next;
      READY       <= (state_next == IDLE);
      BUSY        <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_mtsp_launch.sv
// Directed bench for mtsp_launch: per-cycle vector table plus long hand-written sequences.
module tb_mtsp_launch;

  logic       CLK;
  logic       RST;
  logic       START;
  logic [3:0] CORE_MASK;
  logic       READY;
  logic       BUSY;
  logic [3:0] ACTIVE_MASK;
  logic [3:0] CORE_START;
  logic [3:0] CORE_BUSY;
  logic       DONE;
  logic       ERROR;

  int errors = 0;
  int checks = 0;

  mtsp_launch #(
    .CORE_SIZE (4),
    .ACK_LIMIT (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .CORE_MASK   (CORE_MASK),
    .READY       (READY),
    .BUSY        (BUSY),
    .ACTIVE_MASK (ACTIVE_MASK),
    .CORE_START  (CORE_START),
    .CORE_BUSY   (CORE_BUSY),
    .DONE        (DONE),
    .ERROR       (ERROR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One cycle of inputs; expected outputs are those seen in the following cycle.
  typedef struct {
    logic        rst;
    logic        start;
    logic [3:0]  mask;
    logic [3:0]  busy;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // Packs {READY, BUSY, ACTIVE_MASK, CORE_START, DONE, ERROR}.
  function automatic logic [11:0] o(input logic rdy, input logic bsy, input logic [3:0] act,
                                    input logic [3:0] cs, input logic dn, input logic er);
    return {rdy, bsy, act, cs, dn, er};
  endfunction

  function automatic void add(input logic r, input logic s, input logic [3:0] m,
                              input logic [3:0] b, input logic [11:0] e, input string n);
    vec_t v;
    v.rst = r; v.start = s; v.mask = m; v.busy = b; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic s, input logic [3:0] m, input logic [3:0] b,
                      input logic [11:0] e, input string n);
    logic [11:0] act;
    RST = r; START = s; CORE_MASK = m; CORE_BUSY = b;
    @(posedge CLK);
    #1;
    act = {READY, BUSY, ACTIVE_MASK, CORE_START, DONE, ERROR};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got rdy/bsy/act/cs/dn/er=%b expected %b", n, act, e);
    end
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; CORE_MASK = '0; CORE_BUSY = '0;

    // reset
    add(1, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,0,0), "reset0");
    add(1, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,0,0), "reset1");
    // one-cycle busy pulse is a sticky ack; DONE at n+4, then back-to-back launch
    add(0, 1, 4'h1, 4'h0, o(0,1,4'h1,4'h1,0,0), "t2_launch");
    add(0, 0, 4'h0, 4'h0, o(0,1,4'h1,4'h0,0,0), "t2_wait");
    add(0, 0, 4'h0, 4'h1, o(0,1,4'h1,4'h0,0,0), "t2_pulse_ack");
    add(0, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,1,0), "t2_done");
    add(0, 1, 4'h8, 4'h0, o(0,1,4'h8,4'h8,0,0), "b2b_launch");
    add(0, 0, 4'h0, 4'h0, o(0,1,4'h8,4'h0,0,0), "b2b_wait");
    add(0, 0, 4'h0, 4'h8, o(0,1,4'h8,4'h0,0,0), "b2b_ack");
    add(0, 0, 4'h0, 4'h8, o(0,1,4'h8,4'h0,0,0), "b2b_run");
    add(0, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,1,0), "b2b_done");
    add(0, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,0,0), "b2b_idle");
    // zero mask ignored; START while busy ignored
    add(0, 1, 4'h0, 4'h0, o(1,0,4'h0,4'h0,0,0), "t4_zero_mask");
    add(0, 1, 4'h3, 4'h0, o(0,1,4'h3,4'h3,0,0), "t4_launch");
    add(0, 1, 4'h4, 4'h0, o(0,1,4'h3,4'h0,0,0), "t4_start_in_launch");
    add(0, 0, 4'h0, 4'h3, o(0,1,4'h3,4'h0,0,0), "t4_ack");
    add(0, 1, 4'hF, 4'h3, o(0,1,4'h3,4'h0,0,0), "t4_start_in_run");
    add(0, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,1,0), "t4_done");
    add(0, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,0,0), "t4_idle");
    // busy on unselected core 2 throughout
    add(0, 1, 4'h1, 4'h4, o(0,1,4'h1,4'h1,0,0), "t5_launch");
    add(0, 0, 4'h0, 4'h4, o(0,1,4'h1,4'h0,0,0), "t5_wait");
    add(0, 0, 4'h0, 4'h4, o(0,1,4'h1,4'h0,0,0), "t5_unsel_no_ack");
    add(0, 0, 4'h0, 4'h5, o(0,1,4'h1,4'h0,0,0), "t5_ack");
    add(0, 0, 4'h0, 4'h5, o(0,1,4'h1,4'h0,0,0), "t5_run");
    add(0, 0, 4'h0, 4'h4, o(1,0,4'h0,4'h0,1,0), "t5_done");
    add(0, 0, 4'h0, 4'h4, o(1,0,4'h0,4'h0,0,0), "t5_idle");
    // reset during LAUNCH, reset during RUN (would otherwise complete), then relaunch
    add(0, 1, 4'hF, 4'h0, o(0,1,4'hF,4'hF,0,0), "t6_launch");
    add(1, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,0,0), "t6_rst_launch");
    add(0, 1, 4'h2, 4'h0, o(0,1,4'h2,4'h2,0,0), "t6b_launch");
    add(0, 0, 4'h0, 4'h0, o(0,1,4'h2,4'h0,0,0), "t6b_wait");
    add(0, 0, 4'h0, 4'h2, o(0,1,4'h2,4'h0,0,0), "t6b_ack");
    add(1, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,0,0), "t6b_rst_run");
    add(0, 1, 4'h4, 4'h0, o(0,1,4'h4,4'h4,0,0), "t6c_launch");
    add(0, 0, 4'h0, 4'h0, o(0,1,4'h4,4'h0,0,0), "t6c_wait");
    add(0, 0, 4'h0, 4'h4, o(0,1,4'h4,4'h0,0,0), "t6c_ack");
    add(0, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,1,0), "t6c_done");
    add(0, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,0,0), "t6c_idle");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].mask, vecs[i].busy, vecs[i].exp, vecs[i].name);
    end

    // Mask 1011: busy from n+3, cores 0/1/3 drop at n+10/n+12/n+15; DONE only at n+16.
    for (int k = 0; k <= 17; k++) begin
      logic [3:0]  b;
      logic [11:0] e;
      int          j;
      j = k + 1;
      b = '0;
      b[0] = (k >= 3) && (k < 10);
      b[1] = (k >= 3) && (k < 12);
      b[3] = (k >= 3) && (k < 15);
      if (j == 1)       e = o(0,1,4'hB,4'hB,0,0);
      else if (j <= 15) e = o(0,1,4'hB,4'h0,0,0);
      else if (j == 16) e = o(1,0,4'h0,4'h0,1,0);
      else              e = o(1,0,4'h0,4'h0,0,0);
      step(0, (k == 0), 4'hB, b, e, $sformatf("t1_c%0d", j));
    end

    // Mask 0011, core 1 never acks: ERROR at n+18, no DONE.
    for (int k = 0; k <= 18; k++) begin
      logic [3:0]  b;
      logic [11:0] e;
      int          j;
      j = k + 1;
      b = ((k >= 4) && (k < 7)) ? 4'h1 : 4'h0;
      if (j == 1)       e = o(0,1,4'h3,4'h3,0,0);
      else if (j <= 17) e = o(0,1,4'h3,4'h0,0,0);
      else if (j == 18) e = o(1,0,4'h0,4'h0,0,1);
      else              e = o(1,0,4'h0,4'h0,0,0);
      step(0, (k == 0), 4'h3, b, e, $sformatf("t3_c%0d", j));
    end

    // Launch after a timeout completes normally.
    step(0, 1, 4'h2, 4'h0, o(0,1,4'h2,4'h2,0,0), "t3r_launch");
    step(0, 0, 4'h0, 4'h0, o(0,1,4'h2,4'h0,0,0), "t3r_wait");
    step(0, 0, 4'h0, 4'h2, o(0,1,4'h2,4'h0,0,0), "t3r_ack");
    step(0, 0, 4'h0, 4'h0, o(1,0,4'h0,4'h0,1,0), "t3r_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
